// File: rtl/frame_dec_pkg.sv
// Shared constants for the command frame decoder: FSM state encoding, default
// delimiters and checksum width.
package frame_dec_pkg;

  localparam int unsigned CHK_W = 8;

  localparam logic [7:0] DEFAULT_START = 8'hAA;
  localparam logic [7:0] DEFAULT_STOP  = 8'h55;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCmd     = 3'd1;
  localparam logic [2:0] StLen     = 3'd2;
  localparam logic [2:0] StPayload = 3'd3;
  localparam logic [2:0] StChk     = 3'd4;
  localparam logic [2:0] StStop    = 3'd5;
  localparam logic [2:0] StDone    = 3'd6;

  // Address width of a buffer with `depth` entries, never below one bit.
  function automatic int unsigned addr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cmd_frame_decoder_if.sv
// Byte-stream input, held-frame output and payload read port of the frame decoder.
interface cmd_frame_decoder_if #(
  parameter int unsigned MAX_LEN = 16
);
  import frame_dec_pkg::*;

  localparam int unsigned AW = addr_width(MAX_LEN);

  logic          data_valid;
  logic [7:0]    data;
  logic          frame_valid;
  logic          frame_ack;
  logic [7:0]    frame_cmd;
  logic [7:0]    frame_len;
  logic [AW-1:0] pl_rd_addr;
  logic [7:0]    pl_rd_data;
  logic          err_chk;
  logic          err_len;
  logic          err_stop;
  logic          err_timeout;
  logic          err_ovf;

  modport slave (
    input  data_valid, data, frame_ack, pl_rd_addr,
    output frame_valid, frame_cmd, frame_len, pl_rd_data,
    output err_chk, err_len, err_stop, err_timeout, err_ovf
  );

  modport master (
    output data_valid, data, frame_ack, pl_rd_addr,
    input  frame_valid, frame_cmd, frame_len, pl_rd_data,
    input  err_chk, err_len, err_stop, err_timeout, err_ovf
  );

endinterface

// File: rtl/frame_payload_buf.sv
// Payload store: register array with one synchronous write port and one
// combinational read port. Out-of-range reads return zero.
module frame_payload_buf #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (32'(raddr) < Depth) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/cmd_frame_decoder.sv
// Decodes START,CMD,LEN,payload,CHK,STOP byte frames and holds one checked frame.
// Define FRAME_DEC_TIMEOUT_EN to abort partial frames after TIMEOUT_CYC idle clocks.
module cmd_frame_decoder
  import frame_dec_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  START_BYTE  = DEFAULT_START,
  parameter logic [7:0]  STOP_BYTE   = DEFAULT_STOP
) (
  input logic                clk,
  input logic                rst,
  cmd_frame_decoder_if.slave bus
);

  localparam int unsigned AW = addr_width(MAX_LEN);

  logic [2:0]       state_q, state_d;
  logic [CHK_W-1:0] sum_q, sum_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       pay_cnt_q, pay_cnt_d;
  logic [7:0]       frame_cmd_q, frame_cmd_d;
  logic [7:0]       frame_len_q, frame_len_d;
  logic             err_chk_q, err_chk_d;
  logic             err_len_q, err_len_d;
  logic             err_stop_q, err_stop_d;
  logic             err_ovf_q, err_ovf_d;
  logic [CHK_W-1:0] sum_with_stop;
  logic             wr_en;

  // CHK covers the STOP byte that has not arrived yet, so fold it in up front.
  assign sum_with_stop = sum_q + STOP_BYTE;

`ifdef FRAME_DEC_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        err_to_q, err_to_d;
`endif

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    pay_cnt_d   = pay_cnt_q;
    frame_cmd_d = frame_cmd_q;
    frame_len_d = frame_len_q;
    err_chk_d   = 1'b0;
    err_len_d   = 1'b0;
    err_stop_d  = 1'b0;
    err_ovf_d   = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.data_valid && bus.data == START_BYTE) begin
          state_d = StCmd;
          sum_d   = START_BYTE;
        end
      end
      StCmd: begin
        if (bus.data_valid) begin
          cmd_d   = bus.data;
          sum_d   = sum_q + bus.data;
          state_d = StLen;
        end
      end
      StLen: begin
        if (bus.data_valid) begin
          len_d     = bus.data;
          sum_d     = sum_q + bus.data;
          pay_cnt_d = 8'd0;
          if (bus.data > 8'(MAX_LEN)) begin
            err_len_d = 1'b1;
            state_d   = StIdle;
          end else if (bus.data == 8'd0) begin
            state_d = StChk;
          end else begin
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (bus.data_valid) begin
          wr_en     = 1'b1;
          sum_d     = sum_q + bus.data;
          pay_cnt_d = pay_cnt_q + 8'd1;
          if (pay_cnt_q == len_q - 8'd1) begin
            state_d = StChk;
          end
        end
      end
      StChk: begin
        if (bus.data_valid) begin
          if (bus.data == sum_with_stop) begin
            state_d = StStop;
          end else begin
            err_chk_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StStop: begin
        if (bus.data_valid) begin
          if (bus.data == STOP_BYTE) begin
            state_d     = StDone;
            frame_cmd_d = cmd_q;
            frame_len_d = len_q;
          end else begin
            err_stop_d = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      StDone: begin
        // An ack releases the frame and lets a same-cycle START open the next one.
        if (bus.frame_ack) begin
          state_d = StIdle;
          if (bus.data_valid && bus.data == START_BYTE) begin
            state_d = StCmd;
            sum_d   = START_BYTE;
          end
        end else if (bus.data_valid) begin
          err_ovf_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef FRAME_DEC_TIMEOUT_EN
    to_cnt_d = 32'd0;
    err_to_d = 1'b0;
    if (state_q >= StCmd && state_q <= StStop && !bus.data_valid) begin
      if (to_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
        err_to_d = 1'b1;
        state_d  = StIdle;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sum_q       <= '0;
      cmd_q       <= 8'd0;
      len_q       <= 8'd0;
      pay_cnt_q   <= 8'd0;
      frame_cmd_q <= 8'd0;
      frame_len_q <= 8'd0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_stop_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      pay_cnt_q   <= pay_cnt_d;
      frame_cmd_q <= frame_cmd_d;
      frame_len_q <= frame_len_d;
      err_chk_q   <= err_chk_d;
      err_len_q   <= err_len_d;
      err_stop_q  <= err_stop_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

`ifdef FRAME_DEC_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= 32'd0;
      err_to_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_to_q <= err_to_d;
    end
  end

  assign bus.err_timeout = err_to_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign bus.err_timeout    = 1'b0;
`endif

  frame_payload_buf #(
    .Depth (MAX_LEN),
    .AddrW (AW)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en && !rst),
    .waddr (pay_cnt_q[AW-1:0]),
    .wdata (bus.data),
    .raddr (bus.pl_rd_addr),
    .rdata (bus.pl_rd_data)
  );

  assign bus.frame_valid = (state_q == StDone);
  assign bus.frame_cmd   = frame_cmd_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_stop    = err_stop_q;
  assign bus.err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder with a byte-queue frame model checked every cycle.
module tb_cmd_frame_decoder;

  localparam int unsigned MAXL = 16;
  localparam int unsigned TO   = 40;

  localparam logic [4:0] E_CHK  = 5'b10000;
  localparam logic [4:0] E_LEN  = 5'b01000;
  localparam logic [4:0] E_STOP = 5'b00100;
  localparam logic [4:0] E_TO   = 5'b00010;
  localparam logic [4:0] E_OVF  = 5'b00001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_frame_decoder_if #(.MAX_LEN(MAXL)) bus ();

  cmd_frame_decoder #(
    .MAX_LEN     (MAXL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic checking = 1'b0;
  logic [3:0] rd_rot = 4'd0;
  logic [7:0] seq [$];

  // Model: bytes of the frame in progress plus the held frame.
  logic       m_in, m_held;
  logic [7:0] m_q [$];
  logic [7:0] m_cmd, m_len;
  logic [7:0] m_buf [MAXL];
  logic [4:0] m_err;
  int         m_idle;

  task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic dv, input logic [7:0] d, input logic ack);
    int n;
    int l;
    logic [7:0] s;
    m_err = 5'b0;
    if (r) begin
      m_in = 1'b0; m_q.delete(); m_held = 1'b0;
      m_cmd = 8'h00; m_len = 8'h00; m_idle = 0;
      return;
    end
    if (m_held) begin
      if (!ack) begin
        if (dv) m_err = E_OVF;
        return;
      end
      m_held = 1'b0;
    end
    if (!m_in) begin
      if (dv && d == 8'hAA) begin
        m_in = 1'b1; m_q.delete(); m_q.push_back(d); m_idle = 0;
      end
      return;
    end
    if (!dv) begin
`ifdef FRAME_DEC_TIMEOUT_EN
      m_idle++;
      if (m_idle == TO) begin
        m_err = E_TO; m_in = 1'b0;
      end
`endif
      return;
    end
    m_idle = 0;
    m_q.push_back(d);
    n = m_q.size();
    if (n == 3) begin
      if (int'(d) > MAXL) begin
        m_err = E_LEN; m_in = 1'b0;
      end
      return;
    end
    l = int'(m_q[2]);
    if (n <= 3 + l) begin
      m_buf[n-4] = d;
    end else if (n == 4 + l) begin
      s = 8'h55;
      for (int i = 0; i < n - 1; i++) s = s + m_q[i];
      if (d != s) begin
        m_err = E_CHK; m_in = 1'b0;
      end
    end else begin
      if (d == 8'h55) begin
        m_held = 1'b1; m_cmd = m_q[1]; m_len = m_q[2];
      end else begin
        m_err = E_STOP;
      end
      m_in = 1'b0;
    end
  endtask

  task automatic cyc(input logic r, input logic dv, input logic [7:0] d, input logic ack);
    rst = r; bus.data_valid = dv; bus.data = d; bus.frame_ack = ack;
    bus.pl_rd_addr = rd_rot; rd_rot = rd_rot + 4'd1;
    @(posedge clk);
    model_step(r, dv, d, ack);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_seq();
    foreach (seq[i]) send(seq[i]);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
    bus.pl_rd_addr = a;
    #1;
    expect_eq(name, bus.pl_rd_data, exp);
  endtask

  function automatic logic [4:0] dut_err();
    return {bus.err_chk, bus.err_len, bus.err_stop, bus.err_timeout, bus.err_ovf};
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      expect_eq("frame_valid", bus.frame_valid, m_held);
      expect_eq("frame_cmd", bus.frame_cmd, m_cmd);
      expect_eq("frame_len", bus.frame_len, m_len);
      expect_eq("err_pulses", dut_err(), m_err);
      if (m_held && bus.pl_rd_addr < m_len[3:0] + 5'd0)
        expect_eq("pl_rd_data", bus.pl_rd_data, m_buf[bus.pl_rd_addr]);
    end
  end

  initial begin
    rst = 1'b1; bus.data_valid = 1'b0; bus.data = 8'h00;
    bus.frame_ack = 1'b0; bus.pl_rd_addr = '0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    checking = 1'b1;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    expect_eq("reset_valid", bus.frame_valid, 1'b0);
    expect_eq("reset_cmd", bus.frame_cmd, 8'h00);
    expect_eq("reset_len", bus.frame_len, 8'h00);
    expect_eq("reset_err", dut_err(), 5'b0);
    idle(2);

    // Basic two-byte payload frame; stray bytes in idle are ignored.
    send(8'h12);
    seq = '{8'hAA, 8'h43, 8'h02, 8'h11, 8'h22, 8'h77, 8'h55};
    send_seq();
    expect_eq("f1_valid", bus.frame_valid, 1'b1);
    expect_eq("f1_cmd", bus.frame_cmd, 8'h43);
    expect_eq("f1_len", bus.frame_len, 8'h02);
    rd(4'd0, 8'h11, "f1_buf0");
    rd(4'd1, 8'h22, "f1_buf1");

    // Held frame overrun: each byte dropped with an ovf pulse.
    for (int i = 0; i < 3; i++) begin
      send(8'h01 + 8'(i));
      expect_eq("ovf_pulse", bus.err_ovf, 1'b1);
    end
    idle(1);
    expect_eq("ovf_single", bus.err_ovf, 1'b0);
    expect_eq("ovf_cmd_kept", bus.frame_cmd, 8'h43);
    rd(4'd1, 8'h22, "ovf_buf_kept");

    // Ack together with START opens the zero-length frame.
    cyc(1'b0, 1'b1, 8'hAA, 1'b1);
    expect_eq("ack_start_valid", bus.frame_valid, 1'b0);
    seq = '{8'h4D, 8'h00, 8'h4C, 8'h55};
    send_seq();
    expect_eq("f0_valid", bus.frame_valid, 1'b1);
    expect_eq("f0_cmd", bus.frame_cmd, 8'h4D);
    expect_eq("f0_len", bus.frame_len, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    expect_eq("ack_release", bus.frame_valid, 1'b0);

    // Bad checksum leaves the previous frame's fields untouched.
    seq = '{8'hAA, 8'h4D, 8'h00, 8'h4B};
    send_seq();
    expect_eq("chk_pulse", bus.err_chk, 1'b1);
    send(8'h55);
    expect_eq("chk_no_valid", bus.frame_valid, 1'b0);
    expect_eq("chk_cmd_kept", bus.frame_cmd, 8'h4D);

    // LEN above MAX_LEN, then a good frame.
    seq = '{8'hAA, 8'h43, 8'h11};
    send_seq();
    expect_eq("len_pulse", bus.err_len, 1'b1);
    seq = '{8'hAA, 8'h43, 8'h02, 8'h11, 8'h22, 8'h77, 8'h55};
    send_seq();
    expect_eq("len_then_valid", bus.frame_valid, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Wrong stop byte.
    seq = '{8'hAA, 8'h43, 8'h02, 8'h11, 8'h22, 8'h77, 8'h54};
    send_seq();
    expect_eq("stop_pulse", bus.err_stop, 1'b1);
    idle(1);
    expect_eq("stop_no_valid", bus.frame_valid, 1'b0);

    // Reset mid-payload discards silently.
    seq = '{8'hAA, 8'h43, 8'h02, 8'h11};
    send_seq();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    idle(1);
    expect_eq("rst_mid_err", dut_err(), 5'b0);
    expect_eq("rst_mid_cmd", bus.frame_cmd, 8'h00);
    seq = '{8'h22, 8'h77, 8'h55};
    send_seq();
    expect_eq("rst_mid_no_valid", bus.frame_valid, 1'b0);

    // Full-length frame with a stray ack mid-payload.
    seq = '{8'hAA, 8'h43, 8'h10};
    send_seq();
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(i), (i == 5));
    seq = '{8'hCA, 8'h55};
    send_seq();
    expect_eq("max_valid", bus.frame_valid, 1'b1);
    expect_eq("max_len", bus.frame_len, 8'h10);
    rd(4'd15, 8'h0F, "max_buf15");
    rd(4'd7, 8'h07, "max_buf7");
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Idle gap inside a frame.
    seq = '{8'hAA, 8'h43};
    send_seq();
    idle(TO - 1);
    expect_eq("to_early", bus.err_timeout, 1'b0);
    idle(1);
`ifdef FRAME_DEC_TIMEOUT_EN
    expect_eq("to_pulse", bus.err_timeout, 1'b1);
`else
    expect_eq("to_none", bus.err_timeout, 1'b0);
`endif
    seq = '{8'h02, 8'h11, 8'h22, 8'h77, 8'h55};
    send_seq();
`ifdef FRAME_DEC_TIMEOUT_EN
    expect_eq("to_aborted", bus.frame_valid, 1'b0);
`else
    expect_eq("to_waits", bus.frame_valid, 1'b1);
`endif
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
